// File: rtl/pixel_ce_gen.sv
// -----------------------------------------------------------------------------
// pixel_ce_gen
//
// Fractional-N pixel clock-enable generator running on the 100 MHz system
// clock. A phase accumulator (DDS) adds the increment of the active video
// mode every cycle. Its carry-out becomes a single-cycle pix_ce strobe. The
// average strobe rate is f_clk * INC / 2^ACC_W.
//
// Mode changes use a req/ack handshake. Each change is followed by a settle
// interval, and ready stays low for that interval.
//
// Optional feature macro: PIXEL_CE_COUNT_EN
//   defined   -> ce_count counts pix_ce pulses since ready last rose
//   undefined -> ce_count is tied to zero
//
// Ports
//   clk_100m  in   1       system clock, rising edge
//   reset     in   1       synchronous, active-high
//   mode_sel  in   MODE_W  requested mode, sampled with mode_req
//   mode_req  in   1       single-cycle mode-change request
//   mode_ack  out  1       single-cycle acknowledge
//   mode_err  out  1       with mode_ack: 1 = request rejected
//   pix_ce    out  1       pixel clock-enable strobe
//   ready     out  1       pix_ce stream valid for cur_mode
//   cur_mode  out  MODE_W  active mode
//   ce_count  out  32      pix_ce pulses since ready rose (optional)
// -----------------------------------------------------------------------------
module pixel_ce_gen #(
  parameter int          ACC_W      = 32,
  parameter int          NUM_MODES  = 4,
  parameter int          MODE_W     = 3,
  parameter int          SETTLE_CYC = 16,
  parameter logic [63:0] INC0       = 64'd1081258017,
  parameter logic [63:0] INC1       = 64'd1717986918,
  parameter logic [63:0] INC2       = 64'd2791728742,
  parameter logic [63:0] INC3       = 64'd1073741824,
  parameter logic [63:0] INC4       = 64'd0,
  parameter logic [63:0] INC5       = 64'd0,
  parameter logic [63:0] INC6       = 64'd0,
  parameter logic [63:0] INC7       = 64'd0
) (
  input  logic              clk_100m,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              mode_req,
  output logic              mode_ack,
  output logic              mode_err,
  output logic              pix_ce,
  output logic              ready,
  output logic [MODE_W-1:0] cur_mode,
  output logic [31:0]       ce_count
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [MODE_W:0] NUM_MODES_W = (MODE_W + 1)'(NUM_MODES);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t              state_q,      state_d;
  logic [ACC_W-1:0]    acc_q,        acc_d;
  logic                pix_ce_q,     pix_ce_d;
  logic                ready_q,      ready_d;
  logic                ack_q,        ack_d;
  logic                err_q,        err_d;
  logic [MODE_W-1:0]   cur_mode_q,   cur_mode_d;
  logic [MODE_W-1:0]   pend_mode_q,  pend_mode_d;
  logic                ack_pend_q,   ack_pend_d;
  logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [ACC_W:0]      acc_sum;

  // Increment lookup for a mode; unused mode slots yield zero.
  function automatic logic [ACC_W-1:0] inc_for(input logic [MODE_W-1:0] mode);
    case (int'(mode))
      0:       return INC0[ACC_W-1:0];
      1:       return INC1[ACC_W-1:0];
      2:       return INC2[ACC_W-1:0];
      3:       return INC3[ACC_W-1:0];
      4:       return INC4[ACC_W-1:0];
      5:       return INC5[ACC_W-1:0];
      6:       return INC6[ACC_W-1:0];
      7:       return INC7[ACC_W-1:0];
      default: return {ACC_W{1'b0}};
    endcase
  endfunction

  // Next-state, accumulator and handshake logic.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    pix_ce_d     = 1'b0;
    ready_d      = ready_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    cur_mode_d   = cur_mode_q;
    pend_mode_d  = pend_mode_q;
    ack_pend_d   = ack_pend_q;
    settle_cnt_d = settle_cnt_q;
    // One extra bit catches the carry; the carry is the pixel strobe.
    acc_sum      = {1'b0, acc_q} + {1'b0, inc_for(cur_mode_q)};

    case (state_q)
      ST_SETTLE: begin
        acc_d   = {ACC_W{1'b0}};
        ready_d = 1'b0;
        if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d      = ST_RUN;
          ready_d      = 1'b1;
          settle_cnt_d = {SET_W{1'b0}};
          // A completed mode switch is acknowledged together with ready.
          ack_d        = ack_pend_q;
          ack_pend_d   = 1'b0;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end

      ST_RUN: begin
        acc_d    = acc_sum[ACC_W-1:0];
        pix_ce_d = acc_sum[ACC_W];
        ready_d  = 1'b1;
        if (mode_req) begin
          if ({1'b0, mode_sel} >= NUM_MODES_W) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else if (mode_sel == cur_mode_q) begin
            ack_d = 1'b1;
          end else begin
            // Drop ready at once; the ack waits until the new mode settles.
            state_d     = ST_SWITCH;
            pend_mode_d = mode_sel;
            acc_d       = {ACC_W{1'b0}};
            pix_ce_d    = 1'b0;
            ready_d     = 1'b0;
            ack_pend_d  = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_SWITCH: begin
        cur_mode_d   = pend_mode_q;
        acc_d        = {ACC_W{1'b0}};
        ready_d      = 1'b0;
        settle_cnt_d = {SET_W{1'b0}};
        state_d      = ST_SETTLE;
      end

      default: begin
        acc_d        = {ACC_W{1'b0}};
        ready_d      = 1'b0;
        settle_cnt_d = {SET_W{1'b0}};
        state_d      = ST_SETTLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100m) begin
    if (reset) begin
      state_q      <= ST_SETTLE;
      acc_q        <= {ACC_W{1'b0}};
      pix_ce_q     <= 1'b0;
      ready_q      <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      cur_mode_q   <= {MODE_W{1'b0}};
      pend_mode_q  <= {MODE_W{1'b0}};
      ack_pend_q   <= 1'b0;
      settle_cnt_q <= {SET_W{1'b0}};
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      pix_ce_q     <= pix_ce_d;
      ready_q      <= ready_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      cur_mode_q   <= cur_mode_d;
      pend_mode_q  <= pend_mode_d;
      ack_pend_q   <= ack_pend_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

`ifdef PIXEL_CE_COUNT_EN
  logic [31:0] ce_count_q, ce_count_d;

  // Pulse counter: cleared as ready rises, then counts strobes as they are issued.
  always_comb begin
    ce_count_d = ce_count_q;
    if (ready_d && !ready_q) begin
      ce_count_d = 32'd0;
    end else if (pix_ce_d) begin
      ce_count_d = ce_count_q + 32'd1;
    end else begin
      ce_count_d = ce_count_q;
    end
  end

  // Pulse counter register.
  always_ff @(posedge clk_100m) begin
    if (reset) begin
      ce_count_q <= 32'd0;
    end else begin
      ce_count_q <= ce_count_d;
    end
  end

  assign ce_count = ce_count_q;
`else
  assign ce_count = 32'd0;
`endif

  assign mode_ack = ack_q;
  assign mode_err = err_q;
  assign pix_ce   = pix_ce_q;
  assign ready    = ready_q;
  assign cur_mode = cur_mode_q;

  pixel_ce_gen_chk #(
    .ACC_W (ACC_W),
    .INC0  (INC0), .INC1 (INC1), .INC2 (INC2), .INC3 (INC3),
    .INC4  (INC4), .INC5 (INC5), .INC6 (INC6), .INC7 (INC7)
  ) u_chk (
    .clk      (clk_100m),
    .reset    (reset),
    .pix_ce   (pix_ce_q),
    .ready    (ready_q),
    .mode_ack (ack_q),
    .mode_err (err_q)
  );

endmodule

// -----------------------------------------------------------------------------
// pixel_ce_gen_chk
//
// Checks properties of pixel_ce_gen. It has no outputs and adds no logic.
//
// Ports
//   clk, reset          clock and synchronous reset of the checked block
//   pix_ce, ready       strobe and valid flag under check
//   mode_ack, mode_err  handshake outputs under check
// -----------------------------------------------------------------------------
module pixel_ce_gen_chk #(
  parameter int          ACC_W = 32,
  parameter logic [63:0] INC0  = 64'd0,
  parameter logic [63:0] INC1  = 64'd0,
  parameter logic [63:0] INC2  = 64'd0,
  parameter logic [63:0] INC3  = 64'd0,
  parameter logic [63:0] INC4  = 64'd0,
  parameter logic [63:0] INC5  = 64'd0,
  parameter logic [63:0] INC6  = 64'd0,
  parameter logic [63:0] INC7  = 64'd0
) (
  input logic clk,
  input logic reset,
  input logic pix_ce,
  input logic ready,
  input logic mode_ack,
  input logic mode_err
);

  localparam logic [64:0] INC_LIMIT = 65'd1 << ACC_W;

  // An increment that does not fit in the accumulator would silently truncate.
  if (({1'b0, INC0} >= INC_LIMIT) || ({1'b0, INC1} >= INC_LIMIT) ||
      ({1'b0, INC2} >= INC_LIMIT) || ({1'b0, INC3} >= INC_LIMIT) ||
      ({1'b0, INC4} >= INC_LIMIT) || ({1'b0, INC5} >= INC_LIMIT) ||
      ({1'b0, INC6} >= INC_LIMIT) || ({1'b0, INC7} >= INC_LIMIT)) begin : g_inc_range_bad
    $error("pixel_ce_gen: an INC value is not below 2^ACC_W");
  end

  a_ce_needs_ready : assert property (@(posedge clk) disable iff (reset) pix_ce |-> ready)
    else $error("pixel_ce_gen: pix_ce high while ready low");

  a_err_needs_ack : assert property (@(posedge clk) disable iff (reset) mode_err |-> mode_ack)
    else $error("pixel_ce_gen: mode_err without mode_ack");

endmodule
